crc_stream_engine: RTL and testbench

//  Parametrised streaming CRC generator/checker, successor to the fixed 8-bit Ethernet CRC unit.

---
 rtl/crc_stream_engine.sv | 105 ++++++++++
 tb/tb_crc_stream_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: N-byte beats with a last-beat keep mask, programmable
// polynomial, seed, reflection and final XOR, plus a residue flag for frame-plus-FCS checks.
module crc_stream_engine #(
  parameter int                   CRC_WIDTH   = 32,
  parameter int                   DATA_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
  parameter bit                   REFLECT_IN  = 1'b1,
  parameter bit                   REFLECT_OUT = 1'b1,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter logic [CRC_WIDTH-1:0] RESIDUE     = 32'hC704DD7B
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    init,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  input  logic                    data_last,
  input  logic [DATA_WIDTH/8-1:0] data_keep,
  output logic [CRC_WIDTH-1:0]    crc_out,
  output logic                    crc_valid,
  output logic                    crc_ok
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef logic [CRC_WIDTH-1:0] crc_t;

  crc_t                 crc_reg;
  crc_t                 start_crc;
  crc_t                 next_crc;
  logic [NUM_LANES-1:0] lane_en;

  function automatic logic [7:0] rev_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic crc_t rev_crc(input crc_t x);
    crc_t r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = x[CRC_WIDTH-1-i];
    return r;
  endfunction

  // One byte through the MSB-first shift register; the register never changes orientation.
  function automatic crc_t step_byte(input crc_t c, input logic [7:0] b);
    crc_t       r;
    logic [7:0] d;
    logic       fb;
    r = c;
    d = REFLECT_IN ? rev_byte(b) : b;
    for (int i = 7; i >= 0; i--) begin
      fb = r[CRC_WIDTH-1] ^ d[i];
      r  = {r[CRC_WIDTH-2:0], 1'b0};
      if (fb) r = r ^ POLYNOMIAL;
    end
    return r;
  endfunction

  function automatic crc_t step_beat(input crc_t c, input logic [DATA_WIDTH-1:0] d,
                                     input logic [NUM_LANES-1:0] en);
    crc_t r;
    r = c;
    for (int lane = 0; lane < NUM_LANES; lane++) begin
      if (en[lane]) r = step_byte(r, d[8*lane +: 8]);
    end
    return r;
  endfunction

  function automatic crc_t finalize(input crc_t x);
    return (REFLECT_OUT ? rev_crc(x) : x) ^ XOR_OUT;
  endfunction

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    start_crc = init ? SEED : crc_reg;
    lane_en   = data_last ? data_keep : '1;
    next_crc  = step_beat(start_crc, data_in, lane_en);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      crc_reg   <= SEED;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      crc_ok    <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (data_valid && data_last) begin
        // Rearm for the next frame so it can follow with no idle cycle.
        crc_reg   <= SEED;
        crc_valid <= 1'b1;
        crc_out   <= finalize(next_crc);
        crc_ok    <= (next_crc == RESIDUE);
      end else if (data_valid) begin
        crc_reg <= next_crc;
      end else if (init) begin
        crc_reg <= SEED;
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: CRC32 at 32- and 8-bit beats and CRC-16/CCITT-FALSE,
// compared against byte-wise reference CRC algorithms kept here.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [31:0] d32;  logic [3:0] k32;  logic v32, l32, i32;
  logic [31:0] co32; logic cv32, ok32;
  logic [7:0]  d8;   logic [0:0] k8;   logic v8, l8, i8;
  logic [31:0] co8;  logic cv8, ok8;
  logic [15:0] d16;  logic [1:0] k16;  logic v16, l16, i16;
  logic [15:0] co16; logic cv16, ok16;

  crc_stream_engine u32 (
    .clock(clock), .reset_n(reset_n), .init(i32), .data_in(d32), .data_valid(v32),
    .data_last(l32), .data_keep(k32), .crc_out(co32), .crc_valid(cv32), .crc_ok(ok32));

  crc_stream_engine #(.DATA_WIDTH(8)) u8 (
    .clock(clock), .reset_n(reset_n), .init(i8), .data_in(d8), .data_valid(v8),
    .data_last(l8), .data_keep(k8), .crc_out(co8), .crc_valid(cv8), .crc_ok(ok8));

  crc_stream_engine #(
    .CRC_WIDTH(16), .DATA_WIDTH(16), .POLYNOMIAL(16'h1021), .SEED(16'hFFFF),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
  ) u16 (
    .clock(clock), .reset_n(reset_n), .init(i16), .data_in(d16), .data_valid(v16),
    .data_last(l16), .data_keep(k16), .crc_out(co16), .crc_valid(cv16), .crc_ok(ok16));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] res32_q[$]; logic okq32[$];
  logic [31:0] res8_q[$];  logic okq8[$];
  logic [15:0] res16_q[$];

  always @(negedge clock) begin
    if (cv32) begin res32_q.push_back(co32); okq32.push_back(ok32); end
    if (cv8)  begin res8_q.push_back(co8);   okq8.push_back(ok8);   end
    if (cv16) res16_q.push_back(co16);
  end

  // ---------------- reference models ----------------
  // Reflected (LSB-first) CRC32 register before the final inversion.
  function automatic logic [31:0] crc32_raw(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32_ref(input bq_t q);
    return ~crc32_raw(q);
  endfunction

  // A good frame leaves the normal-orientation register at the CRC32 residue.
  function automatic logic crc32_good(input bq_t q);
    logic [31:0] raw, rev;
    raw = crc32_raw(q);
    for (int i = 0; i < 32; i++) rev[i] = raw[31-i];
    return rev == 32'hC704DD7B;
  endfunction

  function automatic logic [15:0] crc16_ref(input bq_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic bq_t with_fcs(input bq_t q);
    bq_t r;
    logic [31:0] f;
    r = q;
    f = crc32_ref(q);
    for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic beat32(input logic [31:0] d, input logic [3:0] k, input logic last,
                        input logic ini);
    d32 = d; k32 = k; l32 = last; i32 = ini; v32 = 1'b1;
    tick();
    v32 = 1'b0; l32 = 1'b0; i32 = 1'b0; d32 = '0; k32 = '1;
  endtask

  task automatic frame32(input bq_t q, input logic ini, input logic zero_tail);
    int n, idx, cnt;
    logic [31:0] d;
    logic [3:0]  k;
    logic        last;
    n = q.size();
    idx = 0;
    while (idx < n) begin
      cnt = (n - idx > 4) ? 4 : n - idx;
      d = $urandom;
      k = '0;
      for (int j = 0; j < cnt; j++) begin
        d[8*j +: 8] = q[idx+j];
        k[j] = 1'b1;
      end
      last = (idx + cnt == n) && !zero_tail;
      beat32(d, last ? k : 4'($urandom), last, ini && idx == 0);
      idx += cnt;
    end
    if (zero_tail || n == 0) beat32($urandom, 4'b0000, 1'b1, ini && n == 0);
  endtask

  task automatic frame8(input bq_t q);
    foreach (q[i]) begin
      d8 = q[i]; k8 = 1'b1; l8 = (i == q.size() - 1); i8 = 1'b0; v8 = 1'b1;
      tick();
    end
    v8 = 1'b0; l8 = 1'b0;
  endtask

  task automatic frame16(input bq_t q);
    int n, idx, cnt;
    n = q.size();
    idx = 0;
    while (idx < n) begin
      cnt = (n - idx > 2) ? 2 : n - idx;
      d16 = $urandom;
      k16 = (cnt == 2) ? 2'b11 : 2'b01;
      for (int j = 0; j < cnt; j++) d16[8*j +: 8] = q[idx+j];
      l16 = (idx + cnt == n); i16 = 1'b0; v16 = 1'b1;
      tick();
      idx += cnt;
    end
    v16 = 1'b0; l16 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (co32 !== 32'h0 || cv32 !== 1'b0 || ok32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u32: got out=%h valid=%b ok=%b expected 0/0/0", co32, cv32, ok32);
    end
    n_tests++;
    if (co16 !== 16'h0 || cv16 !== 1'b0 || cv8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u16_u8: got out16=%h v16=%b v8=%b expected 0/0/0", co16, cv16, cv8);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_check_value();
    res32_q.delete();
    frame32(str_bytes("123456789"), 1'b0, 1'b0);
    n_tests++;
    if (cv32 !== 1'b1 || co32 !== 32'hCBF43926) begin
      n_fail++;
      $display("FAIL crc32_latency: got valid=%b out=%h expected 1/cbf43926", cv32, co32);
    end
    tick();
    n_tests++;
    if (cv32 !== 1'b0 || co32 !== 32'hCBF43926) begin
      n_fail++;
      $display("FAIL crc32_pulse_hold: got valid=%b out=%h expected 0/cbf43926", cv32, co32);
    end
    tick();
    n_tests++;
    if (res32_q.size() != 1) begin
      n_fail++;
      $display("FAIL crc32_pulse_count: got %0d expected 1", res32_q.size());
    end
  endtask

  task automatic test_dw8_fcs();
    bq_t pkt, bad;
    int bit_pos;
    pkt = with_fcs(rand_bytes(92));
    res8_q.delete(); okq8.delete();
    frame8(pkt);
    tick(); tick();
    n_tests++;
    if (res8_q.size() != 1 || okq8[0] !== 1'b1 || res8_q[0] !== crc32_ref(pkt)) begin
      n_fail++;
      $display("FAIL dw8_good_fcs: got n=%0d ok=%b out=%h expected 1/1/%h",
               res8_q.size(), okq8.size() ? okq8[0] : 1'bx,
               res8_q.size() ? res8_q[0] : 32'hx, crc32_ref(pkt));
    end
    bad = pkt;
    bit_pos = $urandom_range(0, 96*8 - 1);
    bad[bit_pos/8][bit_pos%8] = ~bad[bit_pos/8][bit_pos%8];
    res8_q.delete(); okq8.delete();
    frame8(bad);
    tick(); tick();
    n_tests++;
    if (res8_q.size() != 1 || okq8[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL dw8_bad_fcs: got n=%0d ok=%b expected 1/0", res8_q.size(),
               okq8.size() ? okq8[0] : 1'bx);
    end
  endtask

  task automatic test_crc16();
    bq_t q;
    res16_q.delete();
    frame16(str_bytes("123456789"));
    n_tests++;
    if (cv16 !== 1'b1 || co16 !== 16'h29B1) begin
      n_fail++;
      $display("FAIL crc16_check: got valid=%b out=%h expected 1/29b1", cv16, co16);
    end
    for (int t = 0; t < 4; t++) begin
      q = rand_bytes($urandom_range(1, 17));
      frame16(q);
      n_tests++;
      if (cv16 !== 1'b1 || co16 !== crc16_ref(q)) begin
        n_fail++;
        $display("FAIL crc16_random_%0d: got valid=%b out=%h expected 1/%h", t, cv16, co16,
                 crc16_ref(q));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      res32_q.delete();
      frame32(str_bytes("123456789"), 1'b0, 1'b0);
      frame32(str_bytes("123456789"), pass == 1, 1'b0);
      tick(); tick();
      n_tests++;
      if (res32_q.size() != 2 || res32_q[0] !== 32'hCBF43926 || res32_q[1] !== 32'hCBF43926) begin
        n_fail++;
        $display("FAIL back_to_back_init%0d: got n=%0d first=%h second=%h expected 2/cbf43926",
                 pass, res32_q.size(), res32_q.size() > 0 ? res32_q[0] : 32'hx,
                 res32_q.size() > 1 ? res32_q[1] : 32'hx);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    beat32(32'h34333231, 4'hF, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    n_tests++;
    if (cv32 !== 1'b0 || co32 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_outputs: got valid=%b out=%h expected 0/0", cv32, co32);
    end
    reset_n = 1'b1;
    res32_q.delete();
    frame32(str_bytes("123456789"), 1'b0, 1'b0);
    n_tests++;
    if (cv32 !== 1'b1 || co32 !== 32'hCBF43926) begin
      n_fail++;
      $display("FAIL reset_mid_frame_result: got valid=%b out=%h expected 1/cbf43926", cv32, co32);
    end
    tick();
  endtask

  task automatic test_zero_tail();
    bq_t q;
    q = str_bytes("12345678");
    frame32(q, 1'b0, 1'b1);
    n_tests++;
    if (cv32 !== 1'b1 || co32 !== crc32_ref(q)) begin
      n_fail++;
      $display("FAIL zero_tail: got valid=%b out=%h expected 1/%h", cv32, co32, crc32_ref(q));
    end
    tick();
  endtask

  task automatic test_init_idle();
    bq_t q;
    beat32($urandom, 4'hF, 1'b0, 1'b0);
    beat32($urandom, 4'hF, 1'b0, 1'b0);
    i32 = 1'b1;
    tick();
    i32 = 1'b0;
    n_tests++;
    if (cv32 !== 1'b0) begin
      n_fail++;
      $display("FAIL init_no_result: got valid=%b expected 0", cv32);
    end
    q = rand_bytes(11);
    frame32(q, 1'b0, 1'b0);
    n_tests++;
    if (cv32 !== 1'b1 || co32 !== crc32_ref(q)) begin
      n_fail++;
      $display("FAIL init_restart: got valid=%b out=%h expected 1/%h", cv32, co32, crc32_ref(q));
    end
    // A non-contiguous keep yields an undefined CRC but the next frame must be clean.
    beat32($urandom, 4'hF, 1'b0, 1'b0);
    beat32($urandom, 4'b0101, 1'b1, 1'b0);
    q = rand_bytes(6);
    frame32(q, 1'b0, 1'b0);
    n_tests++;
    if (cv32 !== 1'b1 || co32 !== crc32_ref(q)) begin
      n_fail++;
      $display("FAIL after_sparse_keep: got valid=%b out=%h expected 1/%h", cv32, co32,
               crc32_ref(q));
    end
    tick();
  endtask

  task automatic test_random();
    bq_t q;
    logic [31:0] exp_crc[$];
    logic        exp_ok[$];
    res32_q.delete(); okq32.delete();
    for (int t = 0; t < 30; t++) begin
      q = rand_bytes($urandom_range(0, 23));
      if ($urandom_range(0, 1) == 1) q = with_fcs(q);
      exp_crc.push_back(crc32_ref(q));
      exp_ok.push_back(crc32_good(q));
      frame32(q, 1'($urandom), ($urandom_range(0, 3) == 0) && (q.size() % 4 == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    tick(); tick();
    n_tests++;
    if (res32_q.size() != exp_crc.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d expected %0d", res32_q.size(), exp_crc.size());
    end
    for (int t = 0; t < exp_crc.size() && t < res32_q.size(); t++) begin
      n_tests++;
      if (res32_q[t] !== exp_crc[t] || okq32[t] !== exp_ok[t]) begin
        n_fail++;
        $display("FAIL random_frame_%0d: got out=%h ok=%b expected %h/%b", t, res32_q[t],
                 okq32[t], exp_crc[t], exp_ok[t]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    d32 = '0; k32 = '1; v32 = 1'b0; l32 = 1'b0; i32 = 1'b0;
    d8  = '0; k8  = '1; v8  = 1'b0; l8  = 1'b0; i8  = 1'b0;
    d16 = '0; k16 = '1; v16 = 1'b0; l16 = 1'b0; i16 = 1'b0;
    test_reset();
    test_check_value();
    test_dw8_fcs();
    test_crc16();
    test_back_to_back();
    test_reset_mid_frame();
    test_zero_tail();
    test_init_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
